// File: rtl/ahb_master_arbiter_if.sv
// Requester valid/done bundle plus the AHB-Lite master port driven by ahb_master_arbiter.
// The master modport is the arbiter's view; the slave modport is the requesters/bus side.
interface ahb_master_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_write;
   logic [32*NREQ-1:0]   req_addr;
   logic [32*NREQ-1:0]   req_wdata;
   logic [NREQ-1:0]      req_done;
   logic [31:0]          req_rdata;
   logic [1:0]           req_resp;
   logic [2:0]           grant_id;
   logic                 busy;

   logic [1:0]           htrans;
   logic                 hwrite;
   logic [31:0]          haddr;
   logic [31:0]          hwdata;
   logic [2:0]           hsize;
   logic                 hready_in;
   logic [1:0]           hresp;
   logic [31:0]          hrdata;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, hready_in, hresp, hrdata,
      output req_done, req_rdata, req_resp, grant_id, busy, htrans, hwrite, haddr, hwdata, hsize
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, hready_in, hresp, hrdata,
      input  req_done, req_rdata, req_resp, grant_id, busy, htrans, hwrite, haddr, hwdata, hsize
   );
endinterface

// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter sharing one AHB-Lite master port between NREQ single-transfer requesters.
// Optional define AHB_ARB_TIMEOUT_EN bounds address- and data-phase waits to TIMEOUT_CYC cycles.
module ahb_master_arbiter #(
   parameter int NREQ        = 4,
   parameter int TIMEOUT_CYC = 256
) (
   input logic                  hclk,
   input logic                  rst_n,
   ahb_master_arbiter_if.master bus
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
`ifdef AHB_ARB_TIMEOUT_EN
   localparam logic [1:0]  RESP_ERROR    = 2'b01;
   localparam logic [15:0] TIMEOUT_LAST  = 16'(TIMEOUT_CYC - 1);
`endif

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_badConfig
      $error("ahb_master_arbiter: NREQ must be 2..8 and TIMEOUT_CYC at least 1");
   end

   state_t          state_q, state_d;
   logic [IW-1:0]   rrPtr_q, rrPtr_d;
   logic [2:0]      grant_q, grant_d;
   logic [31:0]     haddr_q, haddr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     hwdata_q, hwdata_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            hwrite_q, hwrite_d;
   logic            busy_q, busy_d;
   logic [1:0]      htrans_q, htrans_d;
   logic [1:0]      resp_q, resp_d;
   logic [NREQ-1:0] done_q, done_d;
`ifdef AHB_ARB_TIMEOUT_EN
   logic [15:0]     timer_q, timer_d;
`endif

   logic [31:0]     addrArr  [NREQ];
   logic [31:0]     wdataArr [NREQ];
   logic [NREQ-1:0] grantOneHot;
   logic            pickFound;
   logic [IW-1:0]   pickIdx;
   logic [IW:0]     cand;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign addrArr[g]  = bus.req_addr[32*g +: 32];
      assign wdataArr[g] = bus.req_wdata[32*g +: 32];
   end

   assign grantOneHot = NREQ'(1) << grant_q;

   // First requesting index at or above the rr pointer, wrapping past NREQ-1.
   always_comb begin
      pickFound = 1'b0;
      pickIdx   = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rrPtr_q} + (IW+1)'(k);
         if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
         if (!pickFound && bus.req_valid[cand[IW-1:0]]) begin
            pickFound = 1'b1;
            pickIdx   = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rrPtr_d  = rrPtr_q;
      grant_d  = grant_q;
      haddr_d  = haddr_q;
      wdata_d  = wdata_q;
      hwdata_d = hwdata_q;
      rdata_d  = rdata_q;
      hwrite_d = hwrite_q;
      busy_d   = busy_q;
      htrans_d = htrans_q;
      resp_d   = resp_q;
      done_d   = '0;
`ifdef AHB_ARB_TIMEOUT_EN
      timer_d  = timer_q;
`endif
      case (state_q)
         IDLE: begin
            if (pickFound) begin
               state_d  = ADDR;
               grant_d  = 3'(pickIdx);
               haddr_d  = addrArr[pickIdx];
               hwrite_d = bus.req_write[pickIdx];
               wdata_d  = wdataArr[pickIdx];
               htrans_d = HTRANS_NONSEQ;
               busy_d   = 1'b1;
`ifdef AHB_ARB_TIMEOUT_EN
               timer_d  = '0;
`endif
            end
         end
         ADDR: begin
            if (bus.hready_in) begin
               state_d  = DATA;
               htrans_d = HTRANS_IDLE;
               hwdata_d = hwrite_q ? wdata_q : '0;
`ifdef AHB_ARB_TIMEOUT_EN
               timer_d  = '0;
            end else if (timer_q == TIMEOUT_LAST) begin
               state_d  = DONE;
               htrans_d = HTRANS_IDLE;
               done_d   = grantOneHot;
               rdata_d  = 32'hDEAD_BEEF;
               resp_d   = RESP_ERROR;
            end else begin
               timer_d  = timer_q + 16'd1;
`endif
            end
         end
         DATA: begin
            // An ERROR response completes only on its second (hready) cycle.
            if (bus.hready_in) begin
               state_d = DONE;
               rdata_d = hwrite_q ? '0 : bus.hrdata;
               resp_d  = bus.hresp;
               done_d  = grantOneHot;
`ifdef AHB_ARB_TIMEOUT_EN
            end else if (timer_q == TIMEOUT_LAST) begin
               state_d = DONE;
               rdata_d = 32'hDEAD_BEEF;
               resp_d  = RESP_ERROR;
               done_d  = grantOneHot;
            end else begin
               timer_d = timer_q + 16'd1;
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            rrPtr_d = (grant_q == 3'(NREQ - 1)) ? '0 : IW'(grant_q + 3'd1);
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge hclk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rrPtr_q  <= '0;
         grant_q  <= '0;
         haddr_q  <= '0;
         wdata_q  <= '0;
         hwdata_q <= '0;
         rdata_q  <= '0;
         hwrite_q <= 1'b0;
         busy_q   <= 1'b0;
         htrans_q <= HTRANS_IDLE;
         resp_q   <= '0;
         done_q   <= '0;
`ifdef AHB_ARB_TIMEOUT_EN
         timer_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         rrPtr_q  <= rrPtr_d;
         grant_q  <= grant_d;
         haddr_q  <= haddr_d;
         wdata_q  <= wdata_d;
         hwdata_q <= hwdata_d;
         rdata_q  <= rdata_d;
         hwrite_q <= hwrite_d;
         busy_q   <= busy_d;
         htrans_q <= htrans_d;
         resp_q   <= resp_d;
         done_q   <= done_d;
`ifdef AHB_ARB_TIMEOUT_EN
         timer_q  <= timer_d;
`endif
      end
   end

   assign bus.req_done  = done_q;
   assign bus.req_rdata = rdata_q;
   assign bus.req_resp  = resp_q;
   assign bus.grant_id  = grant_q;
   assign bus.busy      = busy_q;
   assign bus.htrans    = htrans_q;
   assign bus.hwrite    = hwrite_q;
   assign bus.haddr     = haddr_q;
   assign bus.hwdata    = hwdata_q;
   assign bus.hsize     = 3'b010;

endmodule
